// File: rtl/alu_acc_seq_pkg.sv
// Shared opcode and state definitions for the accumulator ALU.
// The decoder, this block and the benches all import this one package.
package alu_acc_seq_pkg;

    typedef enum logic [3:0] {
        OP_CLA = 4'd0,
        OP_COM = 4'd1,
        OP_SHR = 4'd2,
        OP_CSL = 4'd3,
        OP_ADD = 4'd4,
        OP_STA = 4'd5,
        OP_LDA = 4'd6,
        OP_SUB = 4'd7,
        OP_MUL = 4'd8
    } opcode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier, one multiplier bit per clock.
// done and product are valid together on the final step, so the owner can capture the result on that edge.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0]   mplier;

    assign busy     = (cnt != '0);
    assign done     = (cnt == CW'(1));
    assign prod_nxt = prod + (mplier[0] ? mcand : '0);
    assign product  = prod_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else if (start) begin
            cnt    <= CW'(WIDTH);
            mcand  <= {{WIDTH{1'b0}}, multiplicand};
            mplier <= multiplier;
            prod   <= '0;
        end else if (busy) begin
            prod   <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_acc_seq.sv
// Clocked accumulator ALU with carry/zero flags, valid/ready command intake
// and a multi-cycle multiply delegated to alu_mul_seq.
module alu_acc_seq
    import alu_acc_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic [WIDTH-1:0] store_data,
    output logic             store_valid,
    output logic             done,
    output logic             err
);

    state_e               state, state_nxt;
    logic                 accept;
    logic                 mul_start;
    logic                 mul_busy;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_diff;

    assign accept   = in_valid && in_ready;
    assign zero     = (acc == '0);
    // The extra top bit carries out of ADD and borrows out of SUB.
    assign add_sum  = {1'b0, acc} + {1'b0, operand};
    assign sub_diff = {1'b0, acc} - {1'b0, operand};

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (mul_start),
        .multiplicand (acc),
        .multiplier   (operand),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mul_start = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && op == OPW'(OP_MUL)) begin
                    mul_start = 1'b1;
                    state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (mul_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            carry       <= 1'b0;
            store_data  <= '0;
            store_valid <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done        <= 1'b0;
            err         <= 1'b0;
            store_valid <= 1'b0;
            if (state == S_MUL && mul_done) begin
                acc   <= mul_product[WIDTH-1:0];
                carry <= |mul_product[2*WIDTH-1:WIDTH];
                done  <= 1'b1;
            end else if (accept) begin
                done <= (op != OPW'(OP_MUL));
                case (op)
                    OPW'(OP_CLA): begin
                        acc   <= '0;
                        carry <= 1'b0;
                    end
                    OPW'(OP_COM): acc <= ~acc;
                    OPW'(OP_SHR): begin
                        acc   <= {1'b0, acc[WIDTH-1:1]};
                        carry <= acc[0];
                    end
                    OPW'(OP_CSL): begin
                        acc   <= {acc[WIDTH-2:0], acc[WIDTH-1]};
                        carry <= acc[WIDTH-1];
                    end
                    OPW'(OP_ADD): {carry, acc} <= add_sum;
                    OPW'(OP_STA): begin
                        store_data  <= acc;
                        store_valid <= 1'b1;
                    end
                    OPW'(OP_LDA): acc <= operand;
                    OPW'(OP_SUB): {carry, acc} <= sub_diff;
                    OPW'(OP_MUL): ;
                    default:      err <= 1'b1;
                endcase
            end
        end
    end

    // The multiplier must stay busy for as long as the FSM waits on it.
    mul_busy_in_mul: assert property (@(posedge clk) disable iff (!rst_n)
        (state == S_MUL) |-> mul_busy);

endmodule
